stall_unit: RTL and testbench

STALL_UNIT -- requirements
Module: stall_unit

---
 rtl/stall_unit.sv | 66 ++++++
 tb/tb_stall_unit.sv | 122 ++++++++++++
 2 files changed

// File: rtl/stall_unit.sv
// stall_unit: pipeline hazard control for load-use, taken branches and multi-cycle E-stage ops.
// Stall/flush outputs are combinational from the current state and the E/D hazard inputs.
module stall_unit #(
    parameter int MD_CYCLES = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        resultsrc_e0,
    input  logic [4:0]  rd_e,
    input  logic [4:0]  rs1_d,
    input  logic [4:0]  rs2_d,
    input  logic        pcsrc_e,
    input  logic        md_start_e,
    output logic        stall_f,
    output logic        stall_d,
    output logic        stall_e,
    output logic        flush_d,
    output logic        flush_e,
    output logic        md_busy,
    output logic        md_done,
    output logic [15:0] stall_cnt
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t     r_state;
    logic [4:0] r_cnt;
    logic       w_idle, w_busy, w_done, w_lu, w_md;

    // Outputs are gated by rst so they drop the instant reset is asserted.
    assign w_idle = !rst && r_state == IDLE;
    assign w_busy = !rst && r_state == BUSY;
    assign w_done = !rst && r_state == DONE;
    assign w_md   = w_idle && md_start_e && !pcsrc_e;
    assign w_lu   = w_idle && resultsrc_e0 && rd_e != 5'd0 &&
                    (rd_e == rs1_d || rd_e == rs2_d) && !md_start_e && !pcsrc_e;

    assign stall_f = w_lu || w_md || w_busy;
    assign stall_d = stall_f;
    assign stall_e = w_md || w_busy;
    assign flush_d = (w_idle || w_done) && pcsrc_e;
    assign flush_e = flush_d || w_lu;
    assign md_busy = w_busy;
    assign md_done = w_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cnt     <= 5'd0;
            stall_cnt <= 16'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_state <= w_md ? BUSY : IDLE;
                    r_cnt   <= w_md ? 5'(MD_CYCLES - 3) : r_cnt;
                end
                BUSY: begin
                    r_state <= (r_cnt == 5'd0) ? DONE : BUSY;
                    r_cnt   <= (r_cnt == 5'd0) ? 5'd0 : r_cnt - 5'd1;
                end
                default: r_state <= IDLE;
            endcase
            if (stall_f && stall_cnt != 16'hFFFF)
                stall_cnt <= stall_cnt + 16'd1;
        end
    end
endmodule

// File: tb/tb_stall_unit.sv
// tb_stall_unit: directed scoreboard bench; MD_CYCLES=8 and MD_CYCLES=3 instances share the inputs.
module tb_stall_unit;
    logic        clk = 0, rst = 1;
    logic        resultsrc_e0 = 0, pcsrc_e = 0, md_start_e = 0;
    logic [4:0]  rd_e = 0, rs1_d = 0, rs2_d = 0;
    logic [6:0]  o8, o3;
    logic [15:0] c8, c3;
    int          n_tests = 0, n_fail = 0;

    typedef struct {
        string       nm;
        bit          sel;
        logic [6:0]  eo;
        logic [15:0] ec;
    } exp_t;
    exp_t q[$];

    always #5 clk = ~clk;

    stall_unit #(.MD_CYCLES(8)) u8 (
        .clk(clk), .rst(rst), .resultsrc_e0(resultsrc_e0), .rd_e(rd_e), .rs1_d(rs1_d),
        .rs2_d(rs2_d), .pcsrc_e(pcsrc_e), .md_start_e(md_start_e),
        .stall_f(o8[6]), .stall_d(o8[5]), .stall_e(o8[4]), .flush_d(o8[3]), .flush_e(o8[2]),
        .md_busy(o8[1]), .md_done(o8[0]), .stall_cnt(c8));

    stall_unit #(.MD_CYCLES(3)) u3 (
        .clk(clk), .rst(rst), .resultsrc_e0(resultsrc_e0), .rd_e(rd_e), .rs1_d(rs1_d),
        .rs2_d(rs2_d), .pcsrc_e(pcsrc_e), .md_start_e(md_start_e),
        .stall_f(o3[6]), .stall_d(o3[5]), .stall_e(o3[4]), .flush_d(o3[3]), .flush_e(o3[2]),
        .md_busy(o3[1]), .md_done(o3[0]), .stall_cnt(c3));

    // Monitor: outputs {stall_f,stall_d,stall_e,flush_d,flush_e,md_busy,md_done} every negedge.
    always @(negedge clk) begin
        if (q.size() != 0) begin
            exp_t e;
            logic [6:0]  ao;
            logic [15:0] ac;
            e  = q.pop_front();
            ao = e.sel ? o3 : o8;
            ac = e.sel ? c3 : c8;
            n_tests += 2;
            if (ao !== e.eo) begin
                n_fail++;
                $display("FAIL %s outs: got %b expected %b", e.nm, ao, e.eo);
            end
            if (ac !== e.ec) begin
                n_fail++;
                $display("FAIL %s stall_cnt: got %0d expected %0d", e.nm, ac, e.ec);
            end
        end
    end

    task automatic drive(input logic rs, input logic [4:0] rd, r1, r2, input logic pc, md);
        resultsrc_e0 = rs; rd_e = rd; rs1_d = r1; rs2_d = r2; pcsrc_e = pc; md_start_e = md;
    endtask

    task automatic step(input string nm, input bit sel, input logic rs, input logic [4:0] rd, r1, r2,
                        input logic pc, md, input logic [6:0] eo, input logic [15:0] ec);
        drive(rs, rd, r1, r2, pc, md);
        q.push_back('{nm, sel, eo, ec});
        @(posedge clk);
        #1;
    endtask

    localparam logic [6:0] NONE = 7'b0000000, LU = 7'b1100100, MDS = 7'b1110000,
                           BSY = 7'b1110010, DN = 7'b0000001, BR = 7'b0001100;

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 0;
        step("idle", 0, 0, 0, 0, 0, 0, 0, NONE, 0);
        step("load_use", 0, 1, 5, 0, 5, 0, 0, LU, 0);
        step("after_lu", 0, 0, 0, 0, 0, 0, 0, NONE, 1);
        step("rd_zero", 0, 1, 0, 0, 0, 0, 0, NONE, 1);
        step("md_c0", 0, 0, 0, 0, 0, 0, 1, MDS, 1);
        for (int i = 1; i <= 6; i++)
            step($sformatf("md_busy%0d", i), 0, 1, 5, 5, 0, i == 3, 1, BSY, 16'(1 + i));
        step("md_done", 0, 0, 0, 0, 0, 0, 0, DN, 8);
        step("md_idle", 0, 0, 0, 0, 0, 0, 0, NONE, 8);
        step("br_md", 0, 1, 5, 5, 0, 1, 1, BR, 8);
        step("br_md_idle", 0, 0, 0, 0, 0, 0, 0, NONE, 8);
        step("md2_c0", 0, 0, 0, 0, 0, 0, 1, MDS, 8);
        for (int i = 1; i <= 6; i++)
            step($sformatf("md2_busy%0d", i), 0, 0, 0, 0, 0, 0, 0, BSY, 16'(8 + i));
        step("done_br", 0, 0, 0, 0, 0, 1, 1, BR | DN, 15);
        step("done_md_ign", 0, 0, 0, 0, 0, 0, 0, NONE, 15);
        step("md3_c0", 0, 0, 0, 0, 0, 0, 1, MDS, 15);
        for (int i = 1; i <= 3; i++)
            step($sformatf("md3_busy%0d", i), 0, 0, 0, 0, 0, 0, 0, BSY, 16'(15 + i));
        drive(0, 0, 0, 0, 0, 1);
        q.push_back('{"async_rst", 0, NONE, 0});
        #2 rst = 1;
        @(posedge clk);
        #1 rst = 0;
        step("post_rst", 0, 0, 0, 0, 0, 0, 0, NONE, 0);
        step("md4_c0", 0, 0, 0, 0, 0, 0, 1, MDS, 0);
        for (int i = 1; i <= 6; i++)
            step($sformatf("md4_busy%0d", i), 0, 0, 0, 0, 0, 0, 0, BSY, 16'(i));
        step("md4_done", 0, 0, 0, 0, 0, 0, 0, DN, 7);
        step("md4_idle", 0, 0, 0, 0, 0, 0, 0, NONE, 7);
        rst = 1;
        @(posedge clk);
        #1 rst = 0;
        step("m3_c0", 1, 0, 0, 0, 0, 0, 1, MDS, 0);
        step("m3_busy", 1, 0, 0, 0, 0, 0, 0, BSY, 1);
        step("m3_done", 1, 0, 0, 0, 0, 0, 0, DN, 2);
        step("m3_idle", 1, 0, 0, 0, 0, 0, 0, NONE, 2);
        drive(1, 7, 7, 0, 0, 0);
        repeat (65533) @(posedge clk);
        #1;
        step("sat0", 1, 1, 7, 7, 0, 0, 0, LU, 16'hFFFF);
        step("sat1", 1, 1, 7, 7, 0, 0, 0, LU, 16'hFFFF);
        step("sat_idle", 1, 0, 0, 0, 0, 0, 0, NONE, 16'hFFFF);
        repeat (2) @(negedge clk);
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d left expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
